// File: rtl/mux_pkg.sv
// Shared select encodings and default width for the ALU operand selector.
package mux_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned SEL_WIDTH     = 2;

   typedef enum logic [SEL_WIDTH-1:0] {
      SEL_A       = 2'b00,
      SEL_B       = 2'b01,
      SEL_C       = 2'b10,
      SEL_ILLEGAL = 2'b11
   } sel_e;

   // True for the three select codes that pick a real source.
   function automatic logic sel_is_legal(input logic [SEL_WIDTH-1:0] sel);
      return (sel == SEL_A) || (sel == SEL_B) || (sel == SEL_C);
   endfunction

endpackage : mux_pkg

// File: rtl/mux_3to1.sv
// Registered 3-input selector; the unused code (and any unknown code) yields
// ILLEGAL_VALUE with sel_err raised, one cycle after sampling.
module mux_3to1
   import mux_pkg::*;
#(
   parameter int unsigned      WIDTH         = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] ILLEGAL_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [WIDTH-1:0]     c,
   input  logic [SEL_WIDTH-1:0] sel,
   output logic [WIDTH-1:0]     out,
   output logic                 sel_err
);

   logic [WIDTH-1:0] out_d, out_q;
   logic             sel_err_d, sel_err_q;

   // Source select; the default branch also absorbs X/Z selects as illegal.
   always_comb begin
      out_d     = ILLEGAL_VALUE;
      sel_err_d = 1'b1;
      case (sel)
         SEL_A: begin
            out_d     = a;
            sel_err_d = 1'b0;
         end
         SEL_B: begin
            out_d     = b;
            sel_err_d = 1'b0;
         end
         SEL_C: begin
            out_d     = c;
            sel_err_d = 1'b0;
         end
         default: begin
            out_d     = ILLEGAL_VALUE;
            sel_err_d = 1'b1;
         end
      endcase
   end

   // Output register with synchronous reset dominating all inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         sel_err_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign out     = out_q;
   assign sel_err = sel_err_q;

endmodule : mux_3to1

// File: tb/tb_mux_3to1.sv
// Directed bench for mux_3to1 at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_mux_3to1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a, b, c;
   logic [1:0]  sel;
   logic [31:0] out;
   logic        sel_err;

   logic [7:0]  a8, b8, c8;
   logic [1:0]  sel8;
   logic [7:0]  out8;
   logic        sel_err8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_3to1 #(.WIDTH(32)) u_dut32 (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .c       (c),
      .sel     (sel),
      .out     (out),
      .sel_err (sel_err)
   );

   mux_3to1 #(.WIDTH(8)) u_dut8 (
      .clk     (clk),
      .rst     (rst),
      .a       (a8),
      .b       (b8),
      .c       (c8),
      .sel     (sel8),
      .out     (out8),
      .sel_err (sel_err8)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect32(input string tag, input logic [31:0] exp_out, input logic exp_err);
      check_eq({tag, ".out"}, out, exp_out);
      check_eq({tag, ".err"}, 32'(sel_err), 32'(exp_err));
   endtask

   logic [1:0] sweep_sel [4];
   logic [7:0] sweep_out [4];
   logic       sweep_err [4];

   initial begin
      sweep_sel[0] = 2'b00; sweep_out[0] = 8'hA5; sweep_err[0] = 1'b0;
      sweep_sel[1] = 2'b01; sweep_out[1] = 8'h5A; sweep_err[1] = 1'b0;
      sweep_sel[2] = 2'b10; sweep_out[2] = 8'hFF; sweep_err[2] = 1'b0;
      sweep_sel[3] = 2'b11; sweep_out[3] = 8'h00; sweep_err[3] = 1'b1;

      rst = 1'b1;
      a = 32'h1; b = 32'h2; c = 32'h3; sel = 2'b01;
      a8 = 8'hA5; b8 = 8'h5A; c8 = 8'hFF; sel8 = 2'b11;

      // Reset held two cycles, then release loads b.
      step(); expect32("rst0", 32'h0, 1'b0);
      check_eq("rst0.out8", 32'(out8), 32'h0);
      check_eq("rst0.err8", 32'(sel_err8), 32'h0);
      step(); expect32("rst1", 32'h0, 1'b0);
      rst = 1'b0;
      step(); expect32("release", 32'h2, 1'b0);

      // Select sweep a->b->c->b, one cycle each.
      sel = 2'b00; step(); expect32("sweep_a", 32'h1, 1'b0);
      sel = 2'b01; step(); expect32("sweep_b", 32'h2, 1'b0);
      sel = 2'b10; step(); expect32("sweep_c", 32'h3, 1'b0);
      sel = 2'b01; step(); expect32("sweep_b2", 32'h2, 1'b0);

      // Illegal select and recovery.
      sel = 2'b11; step(); expect32("illegal", 32'h0, 1'b1);
      sel = 2'b00; step(); expect32("recover", 32'h1, 1'b0);

      // Mid-cycle input changes must not reach the registered output.
      sel = 2'b10; a = 32'h99; #2;
      expect32("no_comb", 32'h1, 1'b0);
      a = 32'h1;

      // c tracking while a/b churn.
      sel = 2'b10; c = 32'hDEADBEEF; step(); expect32("trk0", 32'hDEADBEEF, 1'b0);
      c = 32'hFFFFFFFF; a = 32'h55; b = 32'h66; step(); expect32("trk1", 32'hFFFFFFFF, 1'b0);
      c = 32'h0; a = 32'h77; b = 32'h88; step(); expect32("trk2", 32'h0, 1'b0);

      // Mid-stream reset pulse.
      a = 32'h1; b = 32'h2; c = 32'h3; sel = 2'b01;
      step(); expect32("stream", 32'h2, 1'b0);
      rst = 1'b1; step(); expect32("mid_rst", 32'h0, 1'b0);
      rst = 1'b0; step(); expect32("post_rst", 32'h2, 1'b0);

      // Reset must also clear a raised error flag.
      sel = 2'b11; step(); expect32("err_set", 32'h0, 1'b1);
      rst = 1'b1; step(); expect32("err_clr", 32'h0, 1'b0);
      rst = 1'b0;

      // WIDTH=8 instance sweep.
      for (int i = 0; i < 4; i++) begin
         sel8 = sweep_sel[i];
         step();
         check_eq($sformatf("w8_%0d.out", i), 32'(out8), 32'(sweep_out[i]));
         check_eq($sformatf("w8_%0d.err", i), 32'(sel_err8), 32'(sweep_err[i]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mux_3to1
